dmem_responder: RTL

- Data-memory responder for the MIPS core's load/store port; sits on the CPU side of the top level, opposite the core's memory request logic.
- Accepts one word-access request at a time over a valid/ready handshake.
- Inserts a parameterised number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel.
- Flags misaligned and out-of-range accesses with an error response and does not modify memory for them.

---
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one word access at a time, fixed wait states, error on bad address.
// Optional build macro DMEM_BYTE_LANE_EN: when defined, stores honour req_be byte lanes; otherwise every legal store writes the full word.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_wr_c;
  logic [31:0]           offset_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  acc_err_c;
  logic [31:0]           mem_q [DEPTH];

`ifdef DMEM_BYTE_LANE_EN
  logic [3:0]            be_q, be_d;
`else
  logic [3:0]            req_be_unused;
  assign req_be_unused = req_be;
`endif

  // Word index relative to BASE_ADDR; addresses below the base wrap large and fail the range check.
  assign offset_c  = addr_q - BASE_ADDR;
  assign idx_c     = offset_c[DEPTH_LOG2+1:2];
  assign acc_err_c = (addr_q[1:0] != 2'b00) || ((offset_c >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef DMEM_BYTE_LANE_EN
      be_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef DMEM_BYTE_LANE_EN
      be_q         <= be_d;
`endif
    end
  end

  // RESP is entered with resp_valid low; the memory access happens on its first edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_wr_c     = 1'b0;
`ifdef DMEM_BYTE_LANE_EN
    be_d         = be_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
`ifdef DMEM_BYTE_LANE_EN
          be_d        = req_be;
`endif
          req_ready_d = 1'b0;
          cnt_d       = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = acc_err_c;
          resp_rdata_d = 32'd0;
          if (!acc_err_c) begin
            if (we_q) begin
              mem_wr_c = 1'b1;
            end else begin
              resp_rdata_d = mem_q[idx_c];
            end
          end
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Storage is not reset; writes only occur from RESP, which reset forces us out of.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
`ifdef DMEM_BYTE_LANE_EN
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem_q[idx_c] <= wdata_q;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
